// File: rtl/cart_ddr_bridge.sv
// cart_ddr_bridge: serves single-outstanding 16-bit cart requests from a 64-bit DDRAM burst port.
// Define CART_LINE_BUF_EN to add a one-line (64-bit) write-through read buffer.
module cart_ddr_bridge #(
    parameter logic [27:0] DDR_BASE = 28'h1000000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [2:0]  MODE,
    input  logic [24:1] MEM_A,
    input  logic [15:0] MEM_DI,
    input  logic [1:0]  MEM_WE,
    input  logic        MEM_RD,
    output logic [15:0] MEM_DO,
    output logic        MEM_RDY,
    input  logic        DDRAM_BUSY,
    output logic [27:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_RD,
    output logic        DDRAM_WE,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, ACK} state_t;
    state_t state, state_nxt;

    logic [27:0] req_addr;
    logic [1:0]  req_lane;
    logic [7:0]  req_be;
    logic        wr_req, wr_allowed, rd_local;
    logic [1:0]  lane_q;
    logic [15:0] mem_do_nxt;
    logic        mem_rdy_nxt, ddram_rd_nxt, ddram_we_nxt, load_cmd;
    logic        buf_hit;
    logic [63:0] buf_data;

    // Lane 0 is the most significant halfword of the DDR word (big-endian bus).
    function automatic logic [15:0] lane_sel(input logic [63:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return w[63:48];
            2'd1:    return w[47:32];
            2'd2:    return w[31:16];
            default: return w[15:0];
        endcase
    endfunction

    assign req_addr   = DDR_BASE + {6'd0, MEM_A[24:3]};
    assign req_lane   = MEM_A[2:1];
    assign req_be     = {6'd0, MEM_WE} << {~req_lane, 1'b0};
    assign wr_req     = |MEM_WE;
    assign wr_allowed = (MODE == 3'd2) || (MODE == 3'd3) || (MODE == 3'd4);
    assign rd_local   = (MODE == 3'd0);

`ifdef CART_LINE_BUF_EN
    logic [63:0] line_q;
    logic [27:0] tag_q;
    logic        line_vld;
    logic [2:0]  mode_q;
    logic [63:0] wr_data;

    assign wr_data  = {4{MEM_DI}};
    // MODE compare keeps a request issued together with a mode switch from hitting stale data.
    assign buf_hit  = line_vld && (MODE == mode_q) && (tag_q == req_addr);
    assign buf_data = line_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            line_q   <= '0;
            tag_q    <= '0;
            line_vld <= 1'b0;
            mode_q   <= '0;
        end else begin
            mode_q <= MODE;
            if (state == RD_WAIT && DDRAM_DOUT_READY) begin
                line_q   <= DDRAM_DOUT;
                tag_q    <= DDRAM_ADDR;
                line_vld <= 1'b1;
            end else if (state == IDLE && wr_req && wr_allowed && tag_q == req_addr) begin
                for (int i = 0; i < 8; i++)
                    if (req_be[i]) line_q[8*i +: 8] <= wr_data[8*i +: 8];
            end
            if (MODE != mode_q) line_vld <= 1'b0;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_nxt    = state;
        mem_do_nxt   = MEM_DO;
        mem_rdy_nxt  = 1'b0;
        ddram_rd_nxt = DDRAM_RD;
        ddram_we_nxt = DDRAM_WE;
        load_cmd     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    if (wr_allowed) begin
                        load_cmd     = 1'b1;
                        ddram_we_nxt = 1'b1;
                        state_nxt    = WR_CMD;
                    end else begin
                        mem_rdy_nxt = 1'b1;
                        state_nxt   = ACK;
                    end
                end else if (MEM_RD) begin
                    if (rd_local) begin
                        mem_do_nxt  = 16'hFFFF;
                        mem_rdy_nxt = 1'b1;
                        state_nxt   = ACK;
                    end else if (buf_hit) begin
                        mem_do_nxt  = lane_sel(buf_data, req_lane);
                        mem_rdy_nxt = 1'b1;
                        state_nxt   = ACK;
                    end else begin
                        load_cmd     = 1'b1;
                        ddram_rd_nxt = 1'b1;
                        state_nxt    = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (!DDRAM_BUSY) begin
                    ddram_rd_nxt = 1'b0;
                    state_nxt    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    mem_do_nxt  = lane_sel(DDRAM_DOUT, lane_q);
                    mem_rdy_nxt = 1'b1;
                    state_nxt   = ACK;
                end
            end
            WR_CMD: begin
                if (!DDRAM_BUSY) begin
                    ddram_we_nxt = 1'b0;
                    mem_rdy_nxt  = 1'b1;
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                // Hold here until the cart drops the request so it is not re-issued.
                if (!MEM_RD && MEM_WE == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= IDLE;
            MEM_DO         <= 16'hFFFF;
            MEM_RDY        <= 1'b0;
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_BE       <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= 8'd1;
            lane_q         <= '0;
        end else begin
            state          <= state_nxt;
            MEM_DO         <= mem_do_nxt;
            MEM_RDY        <= mem_rdy_nxt;
            DDRAM_RD       <= ddram_rd_nxt;
            DDRAM_WE       <= ddram_we_nxt;
            DDRAM_BURSTCNT <= 8'd1;
            if (load_cmd) begin
                DDRAM_ADDR <= req_addr;
                lane_q     <= req_lane;
                if (wr_req) begin
                    DDRAM_BE  <= req_be;
                    DDRAM_DIN <= {4{MEM_DI}};
                end
            end
        end
    end
endmodule

// File: tb/tb_cart_ddr_bridge.sv
// Scoreboard bench for cart_ddr_bridge: the driver queues expected responses and DDR commands,
// negedge monitors pop and compare whenever MEM_RDY or an accepted DDR command appears.
module tb_cart_ddr_bridge;
    localparam logic [27:0] BASE = 28'h1000000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [2:0]  MODE = '0;
    logic [24:1] MEM_A = '0;
    logic [15:0] MEM_DI = '0;
    logic [1:0]  MEM_WE = '0;
    logic        MEM_RD = 1'b0;
    logic [15:0] MEM_DO;
    logic        MEM_RDY;
    logic        DDRAM_BUSY = 1'b0;
    logic [27:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic        DDRAM_RD;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;

    cart_ddr_bridge #(.DDR_BASE(BASE)) dut (
        .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .MEM_A(MEM_A), .MEM_DI(MEM_DI),
        .MEM_WE(MEM_WE), .MEM_RD(MEM_RD), .MEM_DO(MEM_DO), .MEM_RDY(MEM_RDY),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [15:0] data; int lat; string name; } rsp_t;
    typedef struct { logic wr; logic [27:0] addr; logic [7:0] be; logic [63:0] din; string name; } cmd_t;

    rsp_t        rsp_q[$];
    cmd_t        cmd_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, req_cyc = 0;
    int          busy_left = 0, rd_high = 0, rd_acc = 0, ddr_cnt = 0;
    bit          ddr_pend = 0, rdy_seen = 0;
    logic [63:0] rdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // DDR side model: one cycle of BUSY per remaining busy_left while a command is up,
    // read data returned two edges after the command is accepted.
    always @(posedge CLK) begin
        #1;
        DDRAM_DOUT_READY = 1'b0;
        if (ddr_pend) begin
            if (ddr_cnt == 1) begin
                DDRAM_DOUT       = rdata;
                DDRAM_DOUT_READY = 1'b1;
                ddr_pend         = 0;
            end else ddr_cnt++;
        end
        if ((DDRAM_RD || DDRAM_WE) && busy_left > 0) begin
            DDRAM_BUSY = 1'b1;
            busy_left--;
        end else DDRAM_BUSY = 1'b0;
    end

    always @(negedge CLK) begin
        rsp_t r;
        cmd_t c;
        if (MEM_RDY) begin
            rdy_seen = 1;
            if (rsp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rdy: got MEM_RDY with MEM_DO %h, expected no strobe", MEM_DO);
            end else begin
                r = rsp_q.pop_front();
                chk({r.name, "_do"}, MEM_DO, r.data);
                chk({r.name, "_lat"}, cyc - req_cyc, r.lat);
            end
        end
        if (DDRAM_RD) rd_high++;
        if ((DDRAM_RD || DDRAM_WE) && !DDRAM_BUSY) begin
            if (cmd_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_cmd: got rd=%b we=%b addr %h, expected no command",
                         DDRAM_RD, DDRAM_WE, DDRAM_ADDR);
            end else begin
                c = cmd_q.pop_front();
                chk({c.name, "_cmdwr"}, DDRAM_WE, c.wr);
                chk({c.name, "_addr"}, DDRAM_ADDR, c.addr);
                chk({c.name, "_bcnt"}, DDRAM_BURSTCNT, 8'd1);
                if (c.wr) begin
                    chk({c.name, "_be"}, DDRAM_BE, c.be);
                    chk({c.name, "_din"}, DDRAM_DIN, c.din);
                end
            end
            if (DDRAM_RD) begin
                ddr_pend = 1;
                ddr_cnt  = 0;
                rd_acc++;
            end
        end
    end

    task automatic exp_rsp(input string nm, input logic [15:0] d, input int lat);
        rsp_t r;
        r.name = nm; r.data = d; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic exp_cmd(input string nm, input logic wr, input logic [27:0] a,
                           input logic [7:0] be, input logic [63:0] din);
        cmd_t c;
        c.name = nm; c.wr = wr; c.addr = a; c.be = be; c.din = din;
        cmd_q.push_back(c);
    endtask

    task automatic txn(input string nm, input logic [2:0] mode, input logic [23:0] a,
                       input logic [1:0] we, input logic rd, input logic [15:0] di,
                       input int busy, input int hold);
        @(posedge CLK); #1;
        MODE = mode; MEM_A = a; MEM_WE = we; MEM_RD = rd; MEM_DI = di;
        busy_left = busy; req_cyc = cyc; rdy_seen = 0;
        for (int i = 0; i < 100 && !rdy_seen; i++) @(posedge CLK);
        if (!rdy_seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no MEM_RDY in 100 cycles, expected one", nm);
        end
        repeat (hold) @(posedge CLK);
        #1;
        MEM_RD = 1'b0; MEM_WE = 2'b00;
        repeat (2) @(posedge CLK);
        chk({nm, "_rspq"}, rsp_q.size(), 0);
        chk({nm, "_cmdq"}, cmd_q.size(), 0);
        rsp_q.delete(); cmd_q.delete();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_do"}, MEM_DO, 16'hFFFF);
        chk({nm, "_rdy"}, MEM_RDY, 1'b0);
        chk({nm, "_rd"}, DDRAM_RD, 1'b0);
        chk({nm, "_we"}, DDRAM_WE, 1'b0);
        chk({nm, "_be"}, DDRAM_BE, 8'h00);
        chk({nm, "_din"}, DDRAM_DIN, 64'h0);
        chk({nm, "_addr"}, DDRAM_ADDR, 28'h0);
        chk({nm, "_bcnt"}, DDRAM_BURSTCNT, 8'd1);
    endtask

    initial begin
        int acc0;
        repeat (3) @(posedge CLK);
        #1;
        chk_reset("rst");
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        // Read lane 1 of word 0, held three extra cycles: one DDR read only.
        rdata = 64'h1111_2222_3333_4444;
        exp_cmd("rd_l1", 1'b0, BASE + 28'd0, 8'h00, 64'h0);
        exp_rsp("rd_l1", 16'h2222, 4);
        txn("rd_l1", 3'd3, 24'h000001, 2'b00, 1'b1, 16'h0, 0, 3);

        // Upper-byte write to lane 2, BUSY for 3 cycles.
        exp_cmd("wr_l2", 1'b1, BASE + 28'd0, 8'h08, 64'hABCD_ABCD_ABCD_ABCD);
        exp_rsp("wr_l2", 16'h2222, 5);
        txn("wr_l2", 3'd2, 24'h000002, 2'b10, 1'b0, 16'hABCD, 3, 0);

        // Read lane 3 of word 4 with BUSY high for 10 cycles.
        rdata = 64'hDEAD_BEEF_0123_4567;
        rd_high = 0; acc0 = rd_acc;
        exp_cmd("rd_busy", 1'b0, BASE + 28'd4, 8'h00, 64'h0);
        exp_rsp("rd_busy", 16'h4567, 14);
        txn("rd_busy", 3'd3, 24'h000013, 2'b00, 1'b1, 16'h0, 10, 0);
        chk("rd_busy_rdhigh", rd_high, 11);
        chk("rd_busy_accepted", rd_acc - acc0, 1);

        // Write-protected and local-only modes.
        exp_rsp("wr_rom", 16'h4567, 1);
        txn("wr_rom", 3'd1, 24'h000040, 2'b11, 1'b0, 16'h1234, 0, 0);
        exp_rsp("rd_none", 16'hFFFF, 1);
        txn("rd_none", 3'd0, 24'h000040, 2'b00, 1'b1, 16'h0, 0, 2);
        exp_rsp("wr_stv", 16'hFFFF, 1);
        txn("wr_stv", 3'd5, 24'h000041, 2'b01, 1'b0, 16'h9999, 0, 0);

        // Backup mode read of lane 0.
        rdata = 64'h0102_0304_0506_0708;
        exp_cmd("rd_bkp", 1'b0, BASE + 28'h40, 8'h00, 64'h0);
        exp_rsp("rd_bkp", 16'h0102, 4);
        txn("rd_bkp", 3'd4, 24'h000100, 2'b00, 1'b1, 16'h0, 0, 0);

        // Read, write-through to the same word, reread both lanes.
        rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        exp_cmd("lb_fill", 1'b0, BASE + 28'h80, 8'h00, 64'h0);
        exp_rsp("lb_fill", 16'hAAAA, 4);
        txn("lb_fill", 3'd3, 24'h000200, 2'b00, 1'b1, 16'h0, 0, 0);
        exp_cmd("lb_wr", 1'b1, BASE + 28'h80, 8'hC0, 64'h5A5A_5A5A_5A5A_5A5A);
        exp_rsp("lb_wr", 16'hAAAA, 2);
        txn("lb_wr", 3'd3, 24'h000200, 2'b11, 1'b0, 16'h5A5A, 0, 0);
        rdata = 64'h5A5A_BBBB_CCCC_DDDD;
`ifdef CART_LINE_BUF_EN
        acc0 = rd_acc;
        exp_rsp("lb_hit0", 16'h5A5A, 1);
        txn("lb_hit0", 3'd3, 24'h000200, 2'b00, 1'b1, 16'h0, 0, 0);
        exp_rsp("lb_hit1", 16'hBBBB, 1);
        txn("lb_hit1", 3'd3, 24'h000201, 2'b00, 1'b1, 16'h0, 0, 0);
        chk("lb_no_ddr_rd", rd_acc - acc0, 0);
`else
        exp_cmd("lb_rd0", 1'b0, BASE + 28'h80, 8'h00, 64'h0);
        exp_rsp("lb_rd0", 16'h5A5A, 4);
        txn("lb_rd0", 3'd3, 24'h000200, 2'b00, 1'b1, 16'h0, 0, 0);
        exp_cmd("lb_rd1", 1'b0, BASE + 28'h80, 8'h00, 64'h0);
        exp_rsp("lb_rd1", 16'hBBBB, 4);
        txn("lb_rd1", 3'd3, 24'h000201, 2'b00, 1'b1, 16'h0, 0, 0);
`endif

        // Reset while waiting for read data; the late DOUT_READY must be ignored.
        rdata = 64'h7777_8888_9999_AAAA;
        acc0 = rd_acc;
        exp_cmd("rst_mid", 1'b0, BASE + 28'hC0, 8'h00, 64'h0);
        @(posedge CLK); #1;
        MODE = 3'd3; MEM_A = 24'h000300; MEM_RD = 1'b1; rdy_seen = 0;
        for (int i = 0; i < 50 && rd_acc == acc0; i++) @(posedge CLK);
        chk("rst_mid_accepted", rd_acc - acc0, 1);
        #1;
        RST_N = 1'b0; MEM_RD = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk_reset("rst_mid");
        chk("rst_mid_no_rdy", rdy_seen, 0);
        chk("rst_mid_cmdq", cmd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
